// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and defaults for the sequential binary-to-BCD block.
// Holds the FSM state enum, default WIDTH/DIGITS and the bit-counter width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: one double-dabble digit correction, q = d + 3 when d >= 5.
// Ports: d (4-bit digit in), q (4-bit corrected digit out); combinational.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: bit-serial double-dabble converter, one bit per clock.
// Ports: clk, reset_n (async low), in_valid/in_ready/in_value upstream,
// out_valid/out_ready/out_bcd/out_wrap/out_blank downstream.
// Macro BCD_BLANK_EN enables the leading-zero blank mask on out_blank.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_wrap,
  output logic [DIGITS-1:0]     out_blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_w(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0]    sr;
  logic [WIDTH-1:0]    prev;
  logic                prev_vld;
  logic                wrap_q;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       acc_adj;
  logic [BW-1:0]       acc_nxt;
  logic [BW+WIDTH-1:0] sh;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic                last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == SHIFT) && (cnt == CW'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (acc[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  assign sh      = {acc_adj, sr} << 1;
  assign acc_nxt = sh[BW+WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (accept) begin
      sr       <= in_value;
      acc      <= '0;
      cnt      <= CW'(WIDTH);
      wrap_q   <= prev_vld && (in_value < prev);
      prev     <= in_value;
      prev_vld <= 1'b1;
    end else if (state == SHIFT) begin
      acc <= acc_nxt;
      sr  <= sh[WIDTH-1:0];
      cnt <= cnt - CW'(1);
    end
  end

  // acc only moves in SHIFT, so it is stable for the whole of DONE.
  assign out_bcd  = acc;
  assign out_wrap = wrap_q;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;
  logic              hi_zero;

  // Mask is taken from the final accumulator value on the DONE-entry edge.
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (acc_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= '0;
    end else if (last) begin
      blank_q <= blank_nxt;
    end
  end

  assign out_blank = blank_q;
`else
  assign out_blank = '0;
`endif

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 16, binary input width.
- DIGITS, 5, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.

REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream value present.
- in_ready  out  1  block accepts a value.
- in_value  in  WIDTH  unsigned binary value, e.g. a Fibonacci term.
- out_valid  out  1  conversion result present.
- out_ready  in  1  downstream accepts the result.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- out_wrap  out  1  accepted value was less than the previous accepted value.
- out_blank  out  DIGITS  leading-zero blank mask; bit i refers to digit i.

Function
REQ-003 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-004 IDLE with in_valid=1 SHALL, on that edge (the accept edge):
- capture in_value into the shift register;
- clear the BCD accumulator;
- load the bit counter with WIDTH;
- go to SHIFT.
REQ-005 Each SHIFT edge SHALL add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left by 1, then decrement the counter.
REQ-006 The edge on which the counter reaches 0 SHALL move the FSM to DONE, so out_valid rises exactly WIDTH edges after the accept edge.
REQ-007 DONE SHALL hold out_bcd, out_wrap and out_blank stable until an edge with out_ready=1, then go to IDLE; minimum spacing between accepts is WIDTH+2 cycles.
REQ-008 in_valid while in_ready=0 SHALL be ignored; the upstream holds its data.
REQ-009 out_wrap SHALL be 1 when in_value is less than the previously accepted value.
- Comparison is unsigned, evaluated at accept.
- The first accept after reset SHALL give out_wrap=0.
- An equal value SHALL give 0.
REQ-010 Digit adders SHALL be 4 bits wide; the accumulator SHALL never overflow within the REQ-001 constraint.

Reset
REQ-011 reset_n=0 SHALL asynchronously force:
- state IDLE;
- out_valid=0, out_bcd=0, out_wrap=0, out_blank=0;
- counter=0;
- previous-value-valid flag=0.
in_ready SHALL be 1 from the first edge after release.
REQ-012 Reset during SHIFT or DONE SHALL discard the conversion; no partial result is ever presented.

Configuration
REQ-013 Macro BCD_BLANK_EN:
- Defined: out_blank bit i (i>=1) SHALL be 1 when digit i and all higher digits are 0. Bit 0 SHALL be 0. The mask is registered with the state entering DONE.
- Undefined: out_blank SHALL be tied to 0 and no blank logic synthesised.

Structure
REQ-014 Shared package bcd_pkg SHALL hold:
- the state enum (IDLE/SHIFT/DONE);
- default WIDTH and DIGITS;
- the counter-width localparam, $clog2(WIDTH+1).
REQ-015 Sub-module bcd_add3 (4-bit in, 4-bit out, combinational +3-if->=5) SHALL be instantiated DIGITS times; all other logic stays in bin2bcd_seq.

Verification
REQ-016 Release reset, then in_value=0 with in_valid=1 SHALL give, 16 edges later:
- out_bcd=0x00000;
- out_wrap=0;
- out_blank=5'b11110 with BCD_BLANK_EN, 5'b00000 without.
REQ-017 in_value=65535 SHALL give out_bcd=0x65535 and out_blank=0; in_value=4181 SHALL give out_bcd=0x04181 and out_blank=5'b10000.
REQ-018 Accepting the sequence 28657, 46368, 9489 (16-bit Fibonacci wrap) SHALL give out_wrap=0, 0, 1; out_bcd for the third SHALL be 0x09489.
REQ-019 out_ready held 0 for 10 cycles in DONE SHALL:
- keep out_valid=1 and out_bcd unchanged;
- keep in_ready=0 and ignore new in_valid;
- return to IDLE on the edge after out_ready=1.
REQ-020 reset_n pulsed low at shift 8 of a conversion of 12345 SHALL:
- immediately give out_valid=0;
- never present any output for 12345;
- convert the next accepted value 1 correctly to 0x00001 with out_wrap=0.
